event_indicator: RTL and testbench
==================================

Name: event_indicator

Overview:
Output-side counterpart to the button debouncer. It takes single-cycle event pulses, such as a debounced press, a mine hit or a flag placed, and turns each one into a human-visible LED/buzzer pulse of fixed on and off duration, timed in the same ~763 Hz tick domain the debouncer uses. Events that arrive while a pulse is playing are queued in a saturating pending counter and played back in order. It sits between the game-control logic and the board LED/buzzer pins.

Parameters:
DIV_W, 17, tick divider width; one tick every 2^DIV_W clk cycles (763 Hz at 100 MHz)
ON_TICKS, 8, ticks the output is held high per event; legal range 1..256
OFF_TICKS, 8, ticks the output is held low after each pulse; legal range 1..256
CNT_W, 4, pending-counter width; saturates at 2^CNT_W-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low; the block is in reset while rst==0, sampled on posedge clk
event_in  input  1  one-cycle event strobe from control logic or the debouncer
led_out  output  1  registered visible pulse; high exactly while state==ON
busy  output  1  high when state!=IDLE or pending!=0
pending  output  CNT_W  queued events not yet started
overflow  output  1  one-cycle pulse when an event arrives while pending is already saturated and is not consumed that cycle

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, divider=0, tick_cnt=0, pending=0, led_out=0, busy=0, overflow=0. Reset applies mid-pulse as well: the pulse is aborted and the queue is discarded.
- Divider: free-running DIV_W-bit counter. tick=1 when the divider equals all-ones. The divider and the 8-bit tick_cnt are both cleared on every entry to ON or OFF, so durations are exact.
- Dequeue condition, "start":
  - (state==IDLE, or OFF is ending this cycle) and (pending!=0 or event_in).
  - event_in can be consumed directly (bypass) when pending==0.
- State machine:
  - IDLE -> ON on start.
  - ON: each tick increments tick_cnt. On a tick with tick_cnt==ON_TICKS-1 -> OFF.
  - OFF: on a tick with tick_cnt==OFF_TICKS-1 -> ON if start, else -> IDLE.
- Timing:
  - event_in at cycle t with the block in IDLE gives led_out=1 from t+1.
  - ON lasts exactly ON_TICKS*2^DIV_W cycles; OFF lasts exactly OFF_TICKS*2^DIV_W cycles.
  - Back-to-back queued events repeat with period (ON_TICKS+OFF_TICKS)*2^DIV_W and no IDLE gap.
- Pending arithmetic: next = pending + inc - dec.
  - inc = event_in and not consumed by bypass.
  - dec = start and pending!=0 and not bypass.
  - Simultaneous inc and dec leaves pending unchanged.
  - inc while pending==max and no dec: pending holds at max and overflow=1 for one cycle (the event is dropped).
- led_out, busy, overflow and pending are all registered; there are no combinational paths from event_in to any output.

Decomposition:
- Shared package: state encoding localparams (IDLE/ON/OFF) and the default tick constants (DIV_W=17, standard ON/OFF tick counts). The debouncer and other timed UI blocks use the same constants.
- One sub-module: tick_divider (clk, rst, clr, tick). It is the DIV_W-bit counter with a synchronous clear and is reusable by the debouncer.

Test Plan:
(Bench parameters: DIV_W=4 (16 cycles/tick), ON_TICKS=2, OFF_TICKS=3, CNT_W=2 (max 3).)
1. Single event_in at cycle 10 -> led_out=1 on cycles 11..42 and 0 on cycles 43..90; busy=1 on cycles 11..90 and 0 from cycle 91; pending stays 0 throughout.
2. event_in on cycles 10, 11, 12 -> pending=1 at cycle 12 and 2 at cycle 13; led_out rising edges at cycles 11, 91 and 171; pending falls to 1 at cycle 91 and 0 at cycle 171; busy drops at cycle 251.
3. event_in at cycle 10, then 5 more strobes on cycles 20..24 -> pending saturates at 3 by cycle 23; overflow pulses on cycles 24 and 25; exactly 4 led_out pulses in total.
4. pending==1 and event_in asserted on the OFF-ending tick cycle -> ON restarts on the next cycle; pending stays 1; overflow=0.
5. rst=0 for one cycle at cycle 30 mid-ON with pending=2 -> at cycle 31 led_out=0, pending=0, busy=0, state IDLE. A new event_in at cycle 40 gives led_out=1 at cycle 41 with a full 32-cycle pulse.
6. event_in held for 1 cycle exactly on an ON-to-OFF tick boundary -> pending increments to 1; the next pulse starts exactly 48 cycles later.

Source files
------------

// File: rtl/event_indicator_pkg.sv
// Shared constants and state encoding for the timed UI blocks: the event
// indicator and the button debouncer both run on the same slow tick.
package event_indicator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } ind_state_e;

  // One tick every 2^17 clocks gives roughly 763 Hz from a 100 MHz clock.
  localparam int unsigned DEF_DIV_W     = 17;
  localparam int unsigned DEF_ON_TICKS  = 8;
  localparam int unsigned DEF_OFF_TICKS = 8;
  localparam int unsigned DEF_CNT_W     = 4;
  localparam int unsigned TICK_CNT_W    = 8;

  // Value of the tick counter on the final tick of a phase lasting 'ticks'.
  function automatic logic [TICK_CNT_W-1:0] last_tick(input int unsigned ticks);
    return TICK_CNT_W'(ticks - 32'd1);
  endfunction

endpackage

// File: rtl/event_indicator_tick_divider.sv
// Free-running slow-tick divider with synchronous clear; tick is high for one
// clock whenever the counter sits at all-ones.
module event_indicator_tick_divider #(
  parameter int unsigned DIV_W = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             tick_q;
  logic             tick_d;

  always_comb begin
    cnt_d  = clr ? '0 : cnt_q + DIV_W'(1);
    tick_d = (cnt_d == '1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/event_indicator.sv
// Stretches single-cycle events into fixed on/off LED/buzzer pulses, queueing
// events that arrive mid-pulse in a saturating pending counter.
module event_indicator
  import event_indicator_pkg::*;
#(
  parameter int unsigned DIV_W     = DEF_DIV_W,
  parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
  parameter int unsigned OFF_TICKS = DEF_OFF_TICKS,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_in,
  output logic             led_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam logic [TICK_CNT_W-1:0] ON_LAST  = last_tick(ON_TICKS);
  localparam logic [TICK_CNT_W-1:0] OFF_LAST = last_tick(OFF_TICKS);

  ind_state_e            state_q, state_d;
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]      pending_q, pending_d;
  logic                  led_q, led_d;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;

  logic tick;
  logic div_clr;
  logic on_end;
  logic off_end;
  logic pend_nz;
  logic pend_full;
  logic start;
  logic bypass;
  logic inc;
  logic dec;
  logic enter;

  event_indicator_tick_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .tick (tick)
  );

  // Phase-end detection and the dequeue decision.
  always_comb begin
    on_end    = (state_q == ST_ON)  && tick && (tick_cnt_q == ON_LAST);
    off_end   = (state_q == ST_OFF) && tick && (tick_cnt_q == OFF_LAST);
    pend_nz   = (pending_q != '0);
    pend_full = (pending_q == '1);
    start     = ((state_q == ST_IDLE) || off_end) && (pend_nz || event_in);
    bypass    = start && !pend_nz && event_in;
    inc       = event_in && !bypass;
    dec       = start && pend_nz;
  end

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    pending_d  = pending_q;
    ovf_d      = 1'b0;
    enter      = 1'b0;
    div_clr    = 1'b0;

    unique case (state_q)
      ST_IDLE: if (start)  state_d = ST_ON;
      ST_ON:   if (on_end) state_d = ST_OFF;
      ST_OFF:  if (off_end) state_d = start ? ST_ON : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Every phase entry restarts both the divider and the tick count.
    enter   = (state_d != state_q) && (state_d != ST_IDLE);
    div_clr = enter;
    if (enter) begin
      tick_cnt_d = '0;
    end else if (tick && (state_q != ST_IDLE)) begin
      tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
    end

    if (inc && !dec) begin
      if (pend_full) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      pending_d = pending_q - CNT_W'(1);
    end

    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE) || (pending_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      pending_q  <= '0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      pending_q  <= pending_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_event_indicator.sv
// Scoreboard bench for event_indicator: stimulus queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_event_indicator;

  localparam int unsigned DIV_W     = 4;
  localparam int unsigned ON_TICKS  = 2;
  localparam int unsigned OFF_TICKS = 3;
  localparam int unsigned CNT_W     = 2;

  typedef struct {
    int         cyc;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
    string      tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             event_in = 1'b0;
  logic             led_out;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             overflow;

  int    cyc = 0;
  int    base = 0;
  int    checks = 0;
  int    failures = 0;
  int    pulses = 0;
  logic  led_prev = 1'b0;
  string cur_test = "none";
  exp_t  sb[$];
  exp_t  mon_e;

  event_indicator #(
    .DIV_W     (DIV_W),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .event_in (event_in),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc != cyc ||
          {led_out, busy, pending, overflow} !== {mon_e.led, mon_e.busy, mon_e.pend, mon_e.ovf}) begin
        failures++;
        $display("FAIL %s rel_cyc=%0d got led=%b busy=%b pend=%0d ovf=%b want led=%b busy=%b pend=%0d ovf=%b",
                 mon_e.tag, mon_e.cyc - base, led_out, busy, pending, overflow,
                 mon_e.led, mon_e.busy, mon_e.pend, mon_e.ovf);
      end
    end
    if (led_out === 1'b1 && led_prev !== 1'b1) pulses++;
    led_prev = led_out;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_range(input int lo, input int hi, input logic led,
                              input logic bsy, input logic [1:0] pnd, input logic ovf);
    exp_t e;
    for (int c = lo; c <= hi; c++) begin
      e.cyc  = base + c;
      e.led  = led;
      e.busy = bsy;
      e.pend = pnd;
      e.ovf  = ovf;
      e.tag  = cur_test;
      sb.push_back(e);
    end
  endtask

  task automatic go_to(input int rel);
    while (cyc < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe_at(input int rel);
    go_to(rel);
    event_in = 1'b1;
    @(posedge clk);
    #1;
    event_in = 1'b0;
  endtask

  task automatic start_test(input string name);
    cur_test = name;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    base = cyc;
    pulses = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s drain got=%0d pending_expectations want=0", cur_test, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single event from idle.
    start_test("single");
    expect_range(0, 10, 0, 0, 0, 0);
    expect_range(11, 42, 1, 1, 0, 0);
    expect_range(43, 90, 0, 1, 0, 0);
    expect_range(91, 95, 0, 0, 0, 0);
    strobe_at(10);
    drain();

    // Three back-to-back events queue and replay with no idle gap.
    start_test("burst3");
    expect_range(0, 10, 0, 0, 0, 0);
    expect_range(11, 11, 1, 1, 0, 0);
    expect_range(12, 12, 1, 1, 1, 0);
    expect_range(13, 42, 1, 1, 2, 0);
    expect_range(43, 90, 0, 1, 2, 0);
    expect_range(91, 122, 1, 1, 1, 0);
    expect_range(123, 170, 0, 1, 1, 0);
    expect_range(171, 202, 1, 1, 0, 0);
    expect_range(203, 250, 0, 1, 0, 0);
    expect_range(251, 255, 0, 0, 0, 0);
    strobe_at(10);
    strobe_at(11);
    strobe_at(12);
    drain();

    // Saturation and overflow pulses.
    start_test("saturate");
    expect_range(0, 10, 0, 0, 0, 0);
    expect_range(11, 20, 1, 1, 0, 0);
    expect_range(21, 21, 1, 1, 1, 0);
    expect_range(22, 22, 1, 1, 2, 0);
    expect_range(23, 23, 1, 1, 3, 0);
    expect_range(24, 25, 1, 1, 3, 1);
    expect_range(26, 42, 1, 1, 3, 0);
    expect_range(43, 90, 0, 1, 3, 0);
    expect_range(91, 122, 1, 1, 2, 0);
    expect_range(123, 170, 0, 1, 2, 0);
    expect_range(171, 202, 1, 1, 1, 0);
    expect_range(203, 250, 0, 1, 1, 0);
    expect_range(251, 282, 1, 1, 0, 0);
    expect_range(283, 330, 0, 1, 0, 0);
    expect_range(331, 335, 0, 0, 0, 0);
    strobe_at(10);
    for (int c = 20; c <= 24; c++) strobe_at(c);
    drain();
    checks++;
    if (pulses != 4) begin
      failures++;
      $display("FAIL saturate pulse_count got=%0d want=4", pulses);
    end

    // Event on the OFF-ending tick with one queued: inc and dec cancel.
    start_test("off_end_event");
    expect_range(0, 10, 0, 0, 0, 0);
    expect_range(11, 12, 1, 1, 0, 0);
    expect_range(13, 42, 1, 1, 1, 0);
    expect_range(43, 90, 0, 1, 1, 0);
    expect_range(91, 122, 1, 1, 1, 0);
    expect_range(123, 170, 0, 1, 1, 0);
    expect_range(171, 202, 1, 1, 0, 0);
    expect_range(203, 250, 0, 1, 0, 0);
    expect_range(251, 253, 0, 0, 0, 0);
    strobe_at(10);
    strobe_at(12);
    strobe_at(90);
    drain();

    // Reset mid-pulse discards the queue; a fresh event plays a full pulse.
    start_test("mid_reset");
    expect_range(0, 10, 0, 0, 0, 0);
    expect_range(11, 12, 1, 1, 0, 0);
    expect_range(13, 13, 1, 1, 1, 0);
    expect_range(14, 30, 1, 1, 2, 0);
    expect_range(31, 40, 0, 0, 0, 0);
    expect_range(41, 72, 1, 1, 0, 0);
    expect_range(73, 120, 0, 1, 0, 0);
    expect_range(121, 123, 0, 0, 0, 0);
    strobe_at(10);
    strobe_at(12);
    strobe_at(13);
    go_to(30);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    strobe_at(40);
    drain();

    // Event on the ON-to-OFF tick queues; next pulse follows the full OFF.
    start_test("on_end_event");
    expect_range(0, 10, 0, 0, 0, 0);
    expect_range(11, 42, 1, 1, 0, 0);
    expect_range(43, 90, 0, 1, 1, 0);
    expect_range(91, 122, 1, 1, 0, 0);
    expect_range(123, 170, 0, 1, 0, 0);
    expect_range(171, 173, 0, 0, 0, 0);
    strobe_at(10);
    strobe_at(42);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
